// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one asynchronous-read data RAM between the CPU (C) and the loader (L).
// Each access is window/alignment checked before it reaches the RAM; rejected accesses return an error response.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] DMEM_BASE = 32'h0000_1000,
    parameter logic [ADDRESS_WIDTH-1:0] DMEM_SIZE = 32'h0000_1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_req_valid,
    output logic                     c_req_ready,
    input  logic                     c_req_we,
    input  logic [1:0]               c_req_type,
    input  logic [ADDRESS_WIDTH-1:0] c_req_addr,
    input  logic [DATA_WIDTH-1:0]    c_req_wdata,
    output logic                     c_rsp_valid,
    input  logic                     c_rsp_ready,
    output logic [DATA_WIDTH-1:0]    c_rsp_rdata,
    output logic                     c_rsp_err,
    input  logic                     l_req_valid,
    output logic                     l_req_ready,
    input  logic                     l_req_we,
    input  logic [1:0]               l_req_type,
    input  logic [ADDRESS_WIDTH-1:0] l_req_addr,
    input  logic [DATA_WIDTH-1:0]    l_req_wdata,
    output logic                     l_rsp_valid,
    input  logic                     l_rsp_ready,
    output logic [DATA_WIDTH-1:0]    l_rsp_rdata,
    output logic                     l_rsp_err,
    output logic                     ram_we,
    output logic [1:0]               ram_type,
    output logic [ADDRESS_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0]    ram_wd,
    input  logic [DATA_WIDTH-1:0]    ram_rd
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic GNT_C = 1'b0;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state, state_nxt;
    logic            last_grant, gnt, sel, accept, rsp_fire;
    logic            req_we, req_err;
    logic [1:0]      req_type;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wd;
    logic [AW:0]     span, last_byte, win_hi;
    logic            cap_we, cap_err;
    logic [1:0]      cap_type;
    logic [AW-1:0]   cap_addr;
    logic [DW-1:0]   cap_wd, rsp_rdata;
    logic            rsp_err;

    // L wins only when C is idle or C was served last
    assign sel      = l_req_valid & (~c_req_valid | (last_grant == GNT_C));
    assign accept   = (state == IDLE) & (c_req_valid | l_req_valid) & ~rst;
    assign req_we   = sel ? l_req_we    : c_req_we;
    assign req_type = sel ? l_req_type  : c_req_type;
    assign req_addr = sel ? l_req_addr  : c_req_addr;
    assign req_wd   = sel ? l_req_wdata : c_req_wdata;

    // One extra address bit keeps accesses near 2^AW from wrapping into the window
    always_comb begin
        span = '0;
        case (req_type)
            2'b00:   span = (AW+1)'(3);
            2'b10:   span = (AW+1)'(1);
            default: span = '0;
        endcase
    end

    assign win_hi    = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE} - (AW+1)'(1);
    assign last_byte = {1'b0, req_addr} + span;
    assign req_err   = (req_type == 2'b11)
                     | ((req_type == 2'b00) & (req_addr[1:0] != 2'b00))
                     | ((req_type == 2'b10) & req_addr[0])
                     | (req_addr < DMEM_BASE)
                     | (last_byte > win_hi);

    assign c_req_ready = accept & ~sel;
    assign l_req_ready = accept & sel;
    assign rsp_fire    = (state == RESP) & (gnt ? l_rsp_ready : c_rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = ACCESS;
            ACCESS:                state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            cap_we     <= 1'b0;
            cap_err    <= 1'b0;
            cap_type   <= '0;
            cap_addr   <= '0;
            cap_wd     <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                gnt      <= sel;
                cap_we   <= req_we;
                cap_err  <= req_err;
                cap_type <= req_type;
                cap_addr <= req_addr;
                cap_wd   <= req_wd;
            end
            if (state == ACCESS) begin
                rsp_rdata <= (~cap_we & ~cap_err) ? ram_rd : '0;
                rsp_err   <= cap_err;
            end
            if (rsp_fire) last_grant <= gnt;
        end
    end

    // A reset landing on the access cycle drops the write as well as the response
    assign ram_we   = (state == ACCESS) & cap_we & ~cap_err & ~rst;
    assign ram_type = cap_type;
    assign ram_a    = cap_addr;
    assign ram_wd   = cap_wd;

    assign c_rsp_valid = (state == RESP) & ~gnt;
    assign l_rsp_valid = (state == RESP) & gnt;
    assign c_rsp_rdata = gnt ? '0 : rsp_rdata;
    assign l_rsp_rdata = gnt ? rsp_rdata : '0;
    assign c_rsp_err   = ~gnt & rsp_err;
    assign l_rsp_err   = gnt & rsp_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM, transaction-level reference model, directed and random traffic.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] SIZE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    logic c_req_valid, c_req_ready, c_req_we, c_rsp_valid, c_rsp_ready, c_rsp_err;
    logic l_req_valid, l_req_ready, l_req_we, l_rsp_valid, l_rsp_ready, l_rsp_err;
    logic [1:0] c_req_type, l_req_type, ram_type;
    logic [31:0] c_req_addr, c_req_wdata, c_rsp_rdata, l_req_addr, l_req_wdata, l_rsp_rdata;
    logic ram_we;
    logic [31:0] ram_a, ram_wd, ram_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DMEM_BASE(BASE), .DMEM_SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
        .c_req_type(c_req_type), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
        .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
        .l_req_type(l_req_type), .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
        .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready), .l_rsp_rdata(l_rsp_rdata), .l_rsp_err(l_rsp_err),
        .ram_we(ram_we), .ram_type(ram_type), .ram_a(ram_a), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    // Behavioural byte RAM, little-endian, sign-extending reads
    logic [7:0] ram [0:8191];
    logic [12:0] ra;
    always_comb begin
        ra = ram_a[12:0];
        case (ram_type)
            2'b00:   ram_rd = {ram[13'(ra+13'd3)], ram[13'(ra+13'd2)], ram[13'(ra+13'd1)], ram[ra]};
            2'b01:   ram_rd = {{24{ram[ra][7]}}, ram[ra]};
            2'b10:   ram_rd = {{16{ram[13'(ra+13'd1)][7]}}, ram[13'(ra+13'd1)], ram[ra]};
            default: ram_rd = '0;
        endcase
    end
    always @(posedge clk) begin
        if (ram_we) begin
            ram[ra] <= ram_wd[7:0];
            if (ram_type != 2'b01) ram[13'(ra+13'd1)] <= ram_wd[15:8];
            if (ram_type == 2'b00) begin
                ram[13'(ra+13'd2)] <= ram_wd[23:16];
                ram[13'(ra+13'd3)] <= ram_wd[31:24];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: expected memory image of the window plus access rules
    logic [7:0] ref_mem [0:4095];

    function automatic int nbytes(logic [1:0] ty);
        return (ty == 2'b00) ? 4 : (ty == 2'b10) ? 2 : 1;
    endfunction

    function automatic logic m_err(logic [1:0] ty, logic [31:0] a);
        longint lo = longint'(a);
        longint n = longint'(nbytes(ty));
        return (ty == 2'b11) || (lo % n != 0) || (lo < longint'(BASE)) ||
               (lo + n - 1 > longint'(BASE) + longint'(SIZE) - 1);
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] ty, logic [31:0] a);
        int n = nbytes(ty);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a - BASE) + i]) << (8 * i);
        if (n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic m_store(logic [1:0] ty, logic [31:0] a, logic [31:0] wd);
        for (int i = 0; i < nbytes(ty); i++) ref_mem[int'(a - BASE) + i] = 8'(wd >> (8 * i));
    endtask

    // Transaction engine state
    bit pend [2];
    logic p_we [2];
    logic [1:0] p_ty [2];
    logic [31:0] p_addr [2], p_wd [2];
    int cyc = 0, auto_left = 0, l_hold = 0, exp_last = 1, g = 0, hs_cyc = 0;
    bit busy = 0, gen_always = 0, rnd_ready = 0;
    logic e_we, e_err;
    logic [1:0] e_ty;
    logic [31:0] e_addr, e_wd, e_rd, last_rd;
    logic last_err;
    int grant_port [$];
    int grant_cyc [$];
    int done_cyc [2];

    function automatic logic rv(int p); return (p != 0) ? l_rsp_valid : c_rsp_valid; endfunction
    function automatic logic rr(int p); return (p != 0) ? l_rsp_ready : c_rsp_ready; endfunction
    function automatic logic re(int p); return (p != 0) ? l_rsp_err : c_rsp_err; endfunction
    function automatic logic [31:0] rdat(int p); return (p != 0) ? l_rsp_rdata : c_rsp_rdata; endfunction

    task automatic eng_reset();
        busy = 0; exp_last = 1; pend[0] = 0; pend[1] = 0; auto_left = 0; l_hold = 0;
        grant_port.delete(); grant_cyc.delete();
    endtask

    task automatic post(int p, logic we, logic [1:0] ty, logic [31:0] a, logic [31:0] wd);
        p_we[p] = we; p_ty[p] = ty; p_addr[p] = a; p_wd[p] = wd; pend[p] = 1;
    endtask

    task automatic gen(int p);
        int r;
        logic [1:0] ty;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        ty = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        if (r == 0)      a = 32'h0FF8 + $urandom_range(0, 15);
        else if (r == 1) a = 32'h1FF8 + $urandom_range(0, 7);
        else             a = 32'h1000 + $urandom_range(0, 31);
        if ($urandom_range(0, 4) != 0) begin
            if (ty == 2'b00) a[1:0] = 2'b00;
            else if (ty == 2'b10) a[0] = 1'b0;
        end
        post(p, 1'($urandom_range(0, 1)), ty, a, $urandom);
        auto_left--;
    endtask

    task automatic observe();
        int eg;
        if (rst) begin
            chk("rst_c_req_ready", c_req_ready, 0);
            chk("rst_l_req_ready", l_req_ready, 0);
            chk("rst_ram_we", ram_we, 0);
            return;
        end
        if (!busy) begin
            eg = -1;
            if (pend[0] && pend[1]) eg = 1 - exp_last;
            else if (pend[0]) eg = 0;
            else if (pend[1]) eg = 1;
            chk("c_req_ready", c_req_ready, eg == 0);
            chk("l_req_ready", l_req_ready, eg == 1);
            chk("idle_ram_we", ram_we, 0);
            chk("idle_rsp_valid", {c_rsp_valid, l_rsp_valid}, 0);
            if (eg >= 0) begin
                busy = 1; g = eg; hs_cyc = cyc;
                e_we = p_we[eg]; e_ty = p_ty[eg]; e_addr = p_addr[eg]; e_wd = p_wd[eg];
                e_err = m_err(e_ty, e_addr);
                e_rd = (!e_we && !e_err) ? m_load(e_ty, e_addr) : 32'h0;
                pend[eg] = 0;
                grant_port.push_back(eg);
                grant_cyc.push_back(cyc);
            end
        end else begin
            chk("busy_req_ready", {c_req_ready, l_req_ready}, 0);
            if (cyc == hs_cyc + 1) begin
                chk("acc_ram_we", ram_we, e_we && !e_err);
                chk("acc_ram_a", ram_a, e_addr);
                chk("acc_ram_type", ram_type, e_ty);
                if (e_we) chk("acc_ram_wd", ram_wd, e_wd);
                chk("acc_rsp_valid", {c_rsp_valid, l_rsp_valid}, 0);
                if (e_we && !e_err) m_store(e_ty, e_addr, e_wd);
            end else begin
                chk("rsp_ram_we", ram_we, 0);
                chk("rsp_valid", rv(g), 1);
                chk("rsp_valid_other", rv(1 - g), 0);
                chk("rsp_rdata", rdat(g), e_rd);
                chk("rsp_err", re(g), e_err);
                if (rr(g)) begin
                    busy = 0; exp_last = g; last_rd = rdat(g); last_err = re(g); done_cyc[g] = cyc;
                end
            end
        end
    endtask

    task automatic cycle();
        for (int p = 0; p < 2; p++)
            if (!pend[p] && auto_left > 0 && (gen_always || $urandom_range(0, 2) != 0)) gen(p);
        c_req_valid = pend[0]; c_req_we = p_we[0]; c_req_type = p_ty[0]; c_req_addr = p_addr[0]; c_req_wdata = p_wd[0];
        l_req_valid = pend[1]; l_req_we = p_we[1]; l_req_type = p_ty[1]; l_req_addr = p_addr[1]; l_req_wdata = p_wd[1];
        c_rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        l_rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (busy && g == 1 && l_hold > 0 && cyc >= hs_cyc + 2) begin
            l_rsp_ready = 1'b0;
            l_hold--;
        end
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(int maxc);
        int n = 0;
        while ((pend[0] || pend[1] || busy || auto_left > 0) && n < maxc) begin
            cycle();
            n++;
        end
        if (pend[0] || pend[1] || busy || auto_left > 0) begin
            checks++; errors++;
            $error("FAIL timeout cycles=%0d limit=%0d", n, maxc);
        end
    endtask

    task automatic dir(string tag, int p, logic we, logic [1:0] ty, logic [31:0] a, logic [31:0] wd,
                       logic xerr, logic [31:0] xrd);
        post(p, we, ty, a, wd);
        run_idle(20);
        chk({tag, "_err"}, last_err, xerr);
        chk({tag, "_rdata"}, last_rd, xrd);
    endtask

    task automatic zero_chk(string tag);
        chk({tag, "_req_ready"}, {c_req_ready, l_req_ready}, 0);
        chk({tag, "_rsp_valid"}, {c_rsp_valid, l_rsp_valid}, 0);
        chk({tag, "_c_rdata"}, c_rsp_rdata, 0);
        chk({tag, "_l_rdata"}, l_rsp_rdata, 0);
        chk({tag, "_rsp_err"}, {c_rsp_err, l_rsp_err}, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_type"}, ram_type, 0);
        chk({tag, "_ram_a"}, ram_a, 0);
        chk({tag, "_ram_wd"}, ram_wd, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        for (int p = 0; p < 2; p++) begin
            p_we[p] = 0; p_ty[p] = 0; p_addr[p] = 0; p_wd[p] = 0; done_cyc[p] = 0;
        end
        rst = 1'b1;
        eng_reset();

        // Reset with a CPU request pending: not accepted, outputs cleared
        post(0, 0, 2'b00, 32'h1000, 0);
        cycle();
        @(negedge clk);
        zero_chk("init");
        chk("init_c_ready_with_valid", c_req_ready, 0);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        eng_reset();

        // Both ports always valid: strict alternation starting with C, 3 cycles per grant
        gen_always = 1; auto_left = 6;
        run_idle(100);
        gen_always = 0;
        chk("tie_count", grant_port.size(), 6);
        for (int i = 0; i < 6 && i < grant_port.size(); i++) begin
            chk($sformatf("tie_order%0d", i), grant_port[i], i % 2);
            if (i > 0) chk($sformatf("tie_gap%0d", i), grant_cyc[i] - grant_cyc[i-1], 3);
        end

        // Directed functional and boundary accesses
        dir("st_w",      0, 1, 2'b00, 32'h1000, 32'hDEADBEEF, 0, 32'h0);
        dir("ld_w",      0, 0, 2'b00, 32'h1000, 32'h0, 0, 32'hDEADBEEF);
        dir("ld_b3",     0, 0, 2'b01, 32'h1003, 32'h0, 0, 32'hFFFFFFDE);
        dir("ld_h0",     0, 0, 2'b10, 32'h1000, 32'h0, 0, 32'hFFFFBEEF);
        dir("ld_h2",     1, 0, 2'b10, 32'h1002, 32'h0, 0, 32'hFFFFDEAD);
        dir("st_mis",    0, 1, 2'b00, 32'h1002, 32'h11111111, 1, 32'h0);
        dir("ty11",      0, 0, 2'b11, 32'h1000, 32'h0, 1, 32'h0);
        dir("ld_w_1ffd", 0, 0, 2'b00, 32'h1FFD, 32'h0, 1, 32'h0);
        dir("ld_b_0fff", 0, 0, 2'b01, 32'h0FFF, 32'h0, 1, 32'h0);
        dir("st_b_1fff", 1, 1, 2'b01, 32'h1FFF, 32'h00000080, 0, 32'h0);
        dir("ld_b_1fff", 0, 0, 2'b01, 32'h1FFF, 32'h0, 0, 32'hFFFFFF80);
        dir("ld_b_2000", 0, 0, 2'b01, 32'h2000, 32'h0, 1, 32'h0);
        dir("ld_w_wrap", 0, 0, 2'b00, 32'hFFFFFFFC, 32'h0, 1, 32'h0);
        dir("st_h2",     1, 1, 2'b10, 32'h1002, 32'h00007F01, 0, 32'h0);
        dir("ld_w_after",0, 0, 2'b00, 32'h1000, 32'h0, 0, 32'h7F01BEEF);

        // Loader holds its response for 5 cycles while the CPU waits
        grant_port.delete(); grant_cyc.delete();
        post(1, 0, 2'b00, 32'h1000, 0);
        l_hold = 5;
        cycle();
        post(0, 0, 2'b01, 32'h1000, 0);
        run_idle(40);
        chk("stall_len", done_cyc[1] - grant_cyc[0], 7);
        chk("stall_c_port", grant_port[grant_port.size()-1], 0);
        chk("stall_c_gap", grant_cyc[grant_cyc.size()-1] - done_cyc[1], 1);
        chk("stall_c_rdata", last_rd, 32'hFFFFFFEF);

        // Random traffic with random response back-pressure
        rnd_ready = 1; auto_left = 60;
        run_idle(3000);
        rnd_ready = 0;

        // Reset during the access cycle of a store
        post(0, 1, 2'b00, 32'h1004, 32'hCAFEF00D);
        cycle();
        rst = 1'b1;
        cycle();
        @(negedge clk);
        zero_chk("mid");
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        eng_reset();
        post(0, 0, 2'b00, 32'h1004, 0);
        post(1, 0, 2'b00, 32'h1008, 0);
        run_idle(40);
        chk("post_rst_count", grant_port.size(), 2);
        chk("post_rst_first", grant_port[0], 0);
        chk("post_rst_second", grant_port[1], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
